// File: rtl/gb_timer_ctrl_if.sv
// rtl/gb_timer_ctrl_if.sv - CPU I/O bus and interrupt signals of the timer controller
interface gb_timer_ctrl_if;
  logic       tick;
  logic [1:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output tick, addr, wr, din, input dout, irq);
  modport slave  (input tick, addr, wr, din, output dout, irq);
endinterface

// File: rtl/gb_timer_ctrl.sv
// rtl/gb_timer_ctrl.sv - Game Boy DIV/TIMA/TMA/TAC timer with delayed TMA reload and irq
// Optional DMG write-glitch increments enabled by defining GB_TIMER_GLITCH_EN.
module gb_timer_ctrl #(
  parameter int RELOAD_DELAY = 4
) (
  input  logic            clk,
  input  logic            reset,
  gb_timer_ctrl_if.slave  bus
);

  logic [15:0] div, div_nxt;
  logic [7:0]  tima, tma;
  logic [2:0]  tac, tac_nxt;
  logic        pending;
  logic [3:0]  cnt;
  logic        sel_q, sel_q_nxt;
  logic        irq_q;
  logic        sel, sel_nxt, fall, reload;
  logic        div_wr, tima_wr, tma_wr, tac_wr;
  logic [7:0]  rdata;

  function automatic logic sel_of(input logic [2:0] t, input logic [15:0] d);
    case (t[1:0])
      2'b00:   sel_of = t[2] & d[9];
      2'b01:   sel_of = t[2] & d[3];
      2'b10:   sel_of = t[2] & d[5];
      default: sel_of = t[2] & d[7];
    endcase
  endfunction

  always_comb begin
    div_wr  = bus.wr && (bus.addr == 2'd0);
    tima_wr = bus.wr && (bus.addr == 2'd1);
    tma_wr  = bus.wr && (bus.addr == 2'd2);
    tac_wr  = bus.wr && (bus.addr == 2'd3);
    div_nxt = div_wr ? 16'h0000 : (bus.tick ? div + 16'd1 : div);
    tac_nxt = tac_wr ? bus.din[2:0] : tac;
    sel     = sel_of(tac, div);
    sel_nxt = sel_of(tac_nxt, div_nxt);
`ifdef GB_TIMER_GLITCH_EN
    // Write-induced drops of sel are seen as edges on the following clk.
    sel_q_nxt = sel;
    fall      = sel_q & ~sel;
`else
    sel_q_nxt = (div_wr || tac_wr) ? sel_nxt : sel;
    fall      = sel_q & ~sel & ~(div_wr | tac_wr);
`endif
    reload = pending && bus.tick && (cnt == 4'd1);
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.addr)
      2'd0:    rdata = div[15:8];
      2'd1:    rdata = tima;
      2'd2:    rdata = tma;
      default: rdata = {5'b11111, tac};
    endcase
  end

  assign bus.dout = rdata;
  assign bus.irq  = irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= 16'h0000;
      tima    <= 8'h00;
      tma     <= 8'h00;
      tac     <= 3'b000;
      pending <= 1'b0;
      cnt     <= 4'd0;
      sel_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      div   <= div_nxt;
      tac   <= tac_nxt;
      sel_q <= sel_q_nxt;
      irq_q <= reload;
      if (tma_wr)
        tma <= bus.din;
      if (pending && bus.tick)
        cnt <= cnt - 4'd1;
      // Reload beats a TIMA write; a TIMA write beats an increment.
      if (reload) begin
        tima    <= tma_wr ? bus.din : tma;
        pending <= 1'b0;
      end else if (tima_wr) begin
        tima    <= bus.din;
        pending <= 1'b0;
      end else if (fall) begin
        if (tima == 8'hFF) begin
          tima    <= 8'h00;
          pending <= 1'b1;
          cnt     <= 4'(RELOAD_DELAY);
        end else begin
          tima <= tima + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gb_timer_ctrl.sv
// tb/tb_gb_timer_ctrl.sv - scoreboard bench for gb_timer_ctrl with directed vectors
module tb_gb_timer_ctrl;

  typedef struct {
    string      name;
    logic [7:0] exp_dout;
    logic       exp_irq;
    int         exp_cnt;
  } chk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   irq_total = 0;
  int   exp_irq_total = 0;
  chk_t sb[$];

  gb_timer_ctrl_if bus();

  gb_timer_ctrl #(.RELOAD_DELAY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor: samples at negedge and pops one expectation per presented read.
  always @(negedge clk) begin
    chk_t e;
    if (!reset && bus.irq === 1'b1)
      irq_total++;
    if (chk_en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: read presented with no expectation queued");
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.dout !== e.exp_dout) begin
          failures++;
          $display("FAIL %s dout: got %02h expected %02h", e.name, bus.dout, e.exp_dout);
        end
        checks++;
        if (bus.irq !== e.exp_irq) begin
          failures++;
          $display("FAIL %s irq: got %b expected %b", e.name, bus.irq, e.exp_irq);
        end
        checks++;
        if (irq_total != e.exp_cnt) begin
          failures++;
          $display("FAIL %s irq_count: got %0d expected %0d", e.name, irq_total, e.exp_cnt);
        end
      end
    end
  end

  task automatic step(input logic t, input logic w, input logic [1:0] a, input logic [7:0] d);
    bus.tick = t;
    bus.wr   = w;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic check(input string nm, input logic [1:0] a, input logic [7:0] e, input logic ei);
    chk_t c;
    exp_irq_total += int'(ei);
    c.name     = nm;
    c.exp_dout = e;
    c.exp_irq  = ei;
    c.exp_cnt  = exp_irq_total;
    sb.push_back(c);
    bus.tick = 1'b0;
    bus.wr   = 1'b0;
    bus.addr = a;
    chk_en   = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  initial begin
    logic [7:0] glitch_exp;
    bus.tick = 1'b0;
    bus.wr   = 1'b0;
    bus.addr = 2'd0;
    bus.din  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_div",  2'd0, 8'h00, 1'b0);
    check("rst_tima", 2'd1, 8'h00, 1'b0);
    check("rst_tma",  2'd2, 8'h00, 1'b0);
    check("rst_tac",  2'd3, 8'hF8, 1'b0);

    // Basic count on div[3]: four falling edges in 64 ticks.
    step(1'b0, 1'b1, 2'd3, 8'h05);
    ticks(64);
    step(1'b0, 1'b0, 2'd0, 8'h00);
    check("count_tima", 2'd1, 8'h04, 1'b0);
    check("count_tac",  2'd3, 8'hFD, 1'b0);
    check("count_div",  2'd0, 8'h00, 1'b0);

    // Overflow reload: div=64, next bit-3 fall at 80.
    step(1'b0, 1'b1, 2'd2, 8'hAB);
    step(1'b0, 1'b1, 2'd1, 8'hFF);
    ticks(17);
    check("ovf_w0", 2'd1, 8'h00, 1'b0);
    ticks(1);
    check("ovf_w1", 2'd1, 8'h00, 1'b0);
    ticks(1);
    check("ovf_w2", 2'd1, 8'h00, 1'b0);
    ticks(1);
    check("ovf_w3", 2'd1, 8'h00, 1'b0);
    ticks(1);
    check("ovf_reload", 2'd1, 8'hAB, 1'b1);
    check("ovf_irq_off", 2'd1, 8'hAB, 1'b0);

    // Reload cancel: div=85, fall at 96.
    step(1'b0, 1'b1, 2'd1, 8'hFF);
    ticks(12);
    ticks(2);
    step(1'b0, 1'b1, 2'd1, 8'h42);
    check("cancel_tima", 2'd1, 8'h42, 1'b0);
    ticks(6);
    check("cancel_hold", 2'd1, 8'h42, 1'b0);

    // Reload-clk collision with a TIMA write: div=105, fall at 112.
    step(1'b0, 1'b1, 2'd1, 8'hFF);
    ticks(8);
    ticks(3);
    step(1'b1, 1'b1, 2'd1, 8'h11);
    check("coll_tima_wr", 2'd1, 8'hAB, 1'b1);

    // Reload-clk collision with a TMA write: div=117, fall at 128.
    step(1'b0, 1'b1, 2'd1, 8'hFF);
    ticks(12);
    ticks(3);
    step(1'b1, 1'b1, 2'd2, 8'h22);
    check("coll_tma_wr", 2'd1, 8'h22, 1'b1);
    check("coll_tma_reg", 2'd2, 8'h22, 1'b0);

    // Divider.
    step(1'b0, 1'b1, 2'd3, 8'h00);
    step(1'b0, 1'b1, 2'd0, 8'h5A);
    ticks(16'h1234);
    check("div_1234", 2'd0, 8'h12, 1'b0);
    step(1'b1, 1'b1, 2'd0, 8'hFF);
    check("div_wr_tick", 2'd0, 8'h00, 1'b0);
    ticks(255);
    check("div_low_255", 2'd0, 8'h00, 1'b0);
    ticks(1);
    check("div_low_256", 2'd0, 8'h01, 1'b0);

    // Glitch: div[9]=1 with tac=3'b100, then a DIV write.
    step(1'b0, 1'b1, 2'd1, 8'h10);
    step(1'b0, 1'b1, 2'd3, 8'h04);
    step(1'b0, 1'b1, 2'd0, 8'h00);
    ticks(512);
    step(1'b0, 1'b0, 2'd0, 8'h00);
    check("glitch_pre", 2'd1, 8'h10, 1'b0);
    step(1'b0, 1'b1, 2'd0, 8'h00);
    step(1'b0, 1'b0, 2'd0, 8'h00);
`ifdef GB_TIMER_GLITCH_EN
    glitch_exp = 8'h11;
`else
    glitch_exp = 8'h10;
`endif
    check("glitch_tima", 2'd1, glitch_exp, 1'b0);
    check("glitch_div",  2'd0, 8'h00, 1'b0);

    step(1'b0, 1'b0, 2'd0, 8'h00);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
